// File: rtl/seg_pkg.sv
// Shared types and the hex font used by the seven-segment scroll controller.
package seg_pkg;

  typedef enum logic [1:0] {
    SEG_STATIC = 2'd0,
    SEG_SCROLL = 2'd1,
    SEG_BLINK  = 2'd2
  } seg_mode_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-high {a,b,c,d,e,f,g,dp}; entry 0 sits in the least significant byte.
  localparam logic [15:0][7:0] SEG_FONT = {
    8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };

  function automatic logic [7:0] seg_font(input logic [3:0] nib);
    return SEG_FONT[nib];
  endfunction

endpackage

// File: rtl/seg_hex_font.sv
// Combinational hex nibble to active-high segment pattern.
module seg_hex_font
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] pat_o
);

  assign pat_o = seg_font(nib_i);

endmodule

// File: rtl/seg_scroll_ctrl.sv
// Multi-digit seven-segment driver: static, scrolling or blinking window over a hex message.
module seg_scroll_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int MSG_LEN    = 16,
  parameter int RATE_W     = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 mode,
  input  logic                       load,
  input  logic [4*MSG_LEN-1:0]       msg_data,
  input  logic [RATE_W-1:0]          rate,
  input  logic [NUM_DIGITS-1:0]      dp_mask,
  output logic [8*NUM_DIGITS-1:0]    o_seg,
  output logic [$clog2(MSG_LEN)-1:0] o_offset,
  output logic                       o_step,
  output logic                       o_wrap
);

  localparam int OFF_W = $clog2(MSG_LEN);
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(MSG_LEN - 1);
  localparam logic [OFF_W:0]   LEN_EXT  = (OFF_W + 1)'(MSG_LEN);

  logic [4*MSG_LEN-1:0]    msg_q, msg_d;
  logic [OFF_W-1:0]        offset_q, offset_d;
  logic [RATE_W-1:0]       cnt_q, cnt_d;
  logic                    phase_q, phase_d;
  logic [1:0]              mode_q;
  logic [8*NUM_DIGITS-1:0] seg_q, seg_d;
  logic                    step_q, step_d;
  logic                    wrap_q, wrap_d;

  logic scroll, paced, mode_chg;

  assign scroll   = (mode == SEG_SCROLL);
  assign paced    = scroll || (mode == SEG_BLINK);
  assign mode_chg = (mode != mode_q);

  // Load outranks everything; a mode change swallows the tick of that cycle.
  always_comb begin
    msg_d    = msg_q;
    offset_d = offset_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    step_d   = 1'b0;
    wrap_d   = 1'b0;
    if (load) begin
      msg_d    = msg_data;
      offset_d = '0;
      cnt_d    = '0;
      phase_d  = 1'b0;
    end else if (mode_chg || !paced) begin
      cnt_d = '0;
      if (mode_chg) phase_d = 1'b0;
    end else if (cnt_q == rate) begin
      cnt_d  = '0;
      step_d = 1'b1;
      if (scroll) begin
        if (offset_q == LAST_OFF) begin
          offset_d = '0;
          wrap_d   = 1'b1;
        end else begin
          offset_d = offset_q + OFF_W'(1);
        end
      end else begin
        phase_d = ~phase_q;
      end
    end else begin
      cnt_d = cnt_q + RATE_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [OFF_W:0]   sum;
    logic [OFF_W-1:0] idx;
    logic [7:0]       pat;

    // offset and i are both below MSG_LEN, so one conditional subtract is a full modulo.
    assign sum = {1'b0, offset_q} + (OFF_W + 1)'(i);
    assign idx = (sum >= LEN_EXT) ? OFF_W'(sum - LEN_EXT) : OFF_W'(sum);

    seg_hex_font u_font (
      .nib_i (msg_q[4*idx +: 4]),
      .pat_o (pat)
    );

    assign seg_d[8*i +: 8] = phase_q ? SEG_BLANK : ~(pat | {7'b0, dp_mask[i]});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msg_q    <= '0;
      offset_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      mode_q   <= SEG_STATIC;
      seg_q    <= {NUM_DIGITS{SEG_BLANK}};
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      msg_q    <= msg_d;
      offset_q <= offset_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      mode_q   <= mode;
      seg_q    <= seg_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
    end
  end

  assign o_seg    = seg_q;
  assign o_offset = offset_q;
  assign o_step   = step_q;
  assign o_wrap   = wrap_q;

endmodule
